mem_access_unit: RTL

Load/store initiator that sits between the datapath and the byte-addressable `memory` block, acting as the master side of its address/data/read-enable/write-enable port. It accepts one byte, halfword or word request at a time over a valid/ready handshake. Sub-word stores are performed as a read-modify-write of the containing aligned word. Load data is returned sign- or zero-extended with an error flag for misaligned or out-of-range addresses.

---
 rtl/mem_access_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// Load/store initiator for the byte-addressable memory block. One request at a time;
// sub-word stores run as read-modify-write of the containing aligned word.
module mem_access_unit #(
  parameter int unsigned        AWIDTH    = 32,
  parameter int unsigned        DWIDTH    = 32,
  parameter logic [AWIDTH-1:0]  BASE_ADDR = 32'h0100_0000,
  parameter logic [AWIDTH-1:0]  MEM_BYTES = 32'h0001_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DWIDTH-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  localparam logic [AWIDTH-1:0] LastWordOff = MEM_BYTES - AWIDTH'(4);

  state_e            state_q, state_d;
  logic              we_q, uns_q, err_q;
  logic [AWIDTH-1:0] addr_q;
  logic [1:0]        size_q;
  logic [DWIDTH-1:0] wdata_q, word_q, rdata_q;

  logic              accept, req_err;
  logic [AWIDTH-1:0] req_off;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [DWIDTH-1:0] ld_data, merged;

  assign accept  = req_valid_i && req_ready_o;
  assign req_off = req_addr_i - BASE_ADDR;

  always_comb begin
    req_err = 1'b0;
    if (req_size_i == 2'b11)                             req_err = 1'b1;
    if (req_size_i == 2'b01 && req_addr_i[0])            req_err = 1'b1;
    if (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00) req_err = 1'b1;
    if (req_addr_i < BASE_ADDR || req_off > LastWordOff) req_err = 1'b1;
  end

  // Lane extraction straight from the combinational memory read data.
  assign lane_b = mem_data_i[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = mem_data_i[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = mem_data_i;
    unique case (size_q)
      2'b00:   ld_data = uns_q ? {{(DWIDTH-8){1'b0}}, lane_b}
                               : {{(DWIDTH-8){lane_b[7]}}, lane_b};
      2'b01:   ld_data = uns_q ? {{(DWIDTH-16){1'b0}}, lane_h}
                               : {{(DWIDTH-16){lane_h[15]}}, lane_h};
      default: ld_data = mem_data_i;
    endcase
  end

  always_comb begin
    merged = word_q;
    unique case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err)                                state_d = StResp;
          else if (req_we_i && req_size_i == 2'b10)   state_d = StWr;
          else                                        state_d = StRd;
        end
      end
      StRd:    state_d = we_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  if (resp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      size_q  <= 2'b00;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        addr_q  <= req_addr_i;
        size_q  <= req_size_i;
        wdata_q <= req_wdata_i;
        err_q   <= req_err;
        rdata_q <= '0;
      end
      if (state_q == StRd) begin
        word_q <= mem_data_i;
        if (!we_q) rdata_q <= ld_data;
      end
    end
  end

  // Enables gated by rst combinationally: memory clears itself on write+reset.
  assign req_ready_o    = (state_q == StIdle) && !rst;
  assign mem_read_en_o  = (state_q == StRd) && !rst;
  assign mem_write_en_o = (state_q == StWr) && !rst;
  assign resp_valid_o   = (state_q == StResp) && !rst;
  assign resp_rdata_o   = rdata_q;
  assign resp_err_o     = err_q;
  assign mem_addr_o     = {addr_q[AWIDTH-1:2], 2'b00};
  assign mem_data_o     = merged;

endmodule
